// File: rtl/input_skew_feeder.sv
// Read-side sequencer: streams consecutive rows out of input_buffer and skews
// them diagonally (lane i delayed i+1 cycles) onto the systolic array's west edge.
module input_skew_feeder #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         num_rows,
  output logic                busy,
  output logic                done,
  output logic                buf_cen,
  output logic                buf_wen,
  output logic                buf_retn,
  output logic [AW-1:0]       buf_a,
  input  logic [LANES*DW-1:0] buf_q,
  output logic [LANES*DW-1:0] a_out,
  output logic [LANES-1:0]    a_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] MAX_ROWS   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] DRAIN_LAST = (AW+1)'(LANES - 1);

  state_t        state, state_nx;
  logic [AW:0]   cnt, cnt_nx;
  logic [AW:0]   n_rows, n_rows_nx;
  logic [AW-1:0] addr_nx;
  logic          cen_nx;
  logic          busy_nx;
  logic          done_nx;
  logic          rd_vld;

  assign buf_wen  = 1'b1;
  assign buf_retn = 1'b1;

  // cnt counts reads issued in READ, then LANES flush cycles in DRAIN.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      n_rows  <= '0;
      buf_a   <= '0;
      buf_cen <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_vld  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      n_rows  <= n_rows_nx;
      buf_a   <= addr_nx;
      buf_cen <= cen_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      // Buffer output is registered, so a read issued this cycle lands next cycle.
      rd_vld  <= ~buf_cen;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would otherwise infer a latch.
    state_nx  = state;
    cnt_nx    = cnt;
    n_rows_nx = n_rows;
    addr_nx   = buf_a;
    cen_nx    = 1'b1;
    done_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && (num_rows != '0)) begin
          state_nx  = S_READ;
          n_rows_nx = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
          addr_nx   = base_addr;
          cen_nx    = 1'b0;
          cnt_nx    = (AW+1)'(1);
        end
      end
      S_READ: begin
        if (cnt == n_rows) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end else begin
          cen_nx  = 1'b0;
          addr_nx = buf_a + AW'(1);
          cnt_nx  = cnt + (AW+1)'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + (AW+1)'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] d [0:i];
    logic [i:0]    v;

    // Invalid slots carry zero data, so a_out lanes read 0 whenever a_valid is low.
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        // NOTE: skew stages are reset so a transfer killed by RESET leaves no stale lanes behind.
        for (int j = 0; j <= i; j++) d[j] <= '0;
        v <= '0;
      end else begin
        d[0] <= rd_vld ? buf_q[i*DW +: DW] : '0;
        v[0] <= rd_vld;
        for (int j = 1; j <= i; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end

    assign a_out[i*DW +: DW] = d[i];
    assign a_valid[i]        = v[i];
  end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder: a transfer-level model queues expected
// reads, lane outputs and done; a negedge monitor pops and compares them.
module tb_input_skew_feeder;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int ROWS  = 32;

  typedef struct { int cyc_at; logic [AW-1:0] addr; } exp_rd_t;
  typedef struct { int cyc_at; logic [DW-1:0] data; } exp_lane_t;

  logic                CLK;
  logic                RESET;
  logic                start;
  logic [AW-1:0]       base_addr;
  logic [AW:0]         num_rows;
  logic                busy;
  logic                done;
  logic                buf_cen;
  logic                buf_wen;
  logic                buf_retn;
  logic [AW-1:0]       buf_a;
  logic [LANES*DW-1:0] buf_q;
  logic [LANES*DW-1:0] a_out;
  logic [LANES-1:0]    a_valid;

  input_skew_feeder #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .buf_cen   (buf_cen),
    .buf_wen   (buf_wen),
    .buf_retn  (buf_retn),
    .buf_a     (buf_a),
    .buf_q     (buf_q),
    .a_out     (a_out),
    .a_valid   (a_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: after rising edge E, cyc == E.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Buffer model: registered read port.
  logic [LANES*DW-1:0] mem [ROWS];
  always @(posedge CLK) if (!buf_cen) buf_q <= mem[buf_a];

  exp_rd_t   rd_q [$];
  exp_lane_t lane_q [LANES][$];
  int        done_q [$];
  int        busy_from = 1;
  int        busy_to   = 0;
  int        free_edge = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer-level model: decides acceptance and schedules every expected event.
  // Called at a negedge; the inputs are sampled at the next edge k = cyc+1.
  task automatic drive(input logic st, input int b, input int n);
    int k;
    int nn;
    int addr;
    start     = st;
    base_addr = AW'(b);
    num_rows  = (AW+1)'(n);
    k = cyc + 1;
    if (st && n != 0 && k >= free_edge) begin
      nn = (n > ROWS) ? ROWS : n;
      for (int r = 0; r < nn; r++) begin
        addr = (b + r) % ROWS;
        rd_q.push_back('{cyc_at: k + r, addr: AW'(addr)});
        for (int i = 0; i < LANES; i++)
          lane_q[i].push_back('{cyc_at: k + 2 + r + i, data: mem[addr][i*DW +: DW]});
      end
      done_q.push_back(k + nn + 16);
      busy_from = k;
      busy_to   = k + nn + 15;
      free_edge = k + nn + 17;
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_buf_cen"}, buf_cen, 1);
    check({tag, "_buf_a"}, buf_a, 0);
    check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_a_out_nonzero"}, (a_out != '0), 0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    rd_q.delete();
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    done_q.delete();
    busy_from = 1;
    busy_to   = 0;
    free_edge = cyc + 1;
    @(negedge CLK);
    check_reset_state("mid_reset");
    RESET = 1'b1;
  endtask

  function automatic int pending();
    int s;
    s = rd_q.size() + done_q.size();
    for (int i = 0; i < LANES; i++) s += lane_q[i].size();
    return s;
  endfunction

  // Monitor: compares whatever the DUT presents against the scheduled events.
  always @(negedge CLK) begin
    exp_rd_t   er;
    exp_lane_t el;
    int        ed;
    check("buf_wen", buf_wen, 1);
    check("buf_retn", buf_retn, 1);
    check("busy", busy, (cyc >= busy_from && cyc <= busy_to));

    if (!buf_cen) begin
      if (rd_q.size() == 0) check("rd_spurious", buf_cen, 1);
      else begin
        er = rd_q.pop_front();
        check("rd_edge", cyc, er.cyc_at);
        check("rd_addr", buf_a, er.addr);
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc_at <= cyc) begin
      check("rd_missing", buf_cen, 0);
      void'(rd_q.pop_front());
    end

    for (int i = 0; i < LANES; i++) begin
      if (a_valid[i]) begin
        if (lane_q[i].size() == 0) check($sformatf("lane%0d_spurious", i), a_valid[i], 0);
        else begin
          el = lane_q[i].pop_front();
          check($sformatf("lane%0d_edge", i), cyc, el.cyc_at);
          check($sformatf("lane%0d_data", i), a_out[i*DW +: DW], el.data);
        end
      end else begin
        check($sformatf("lane%0d_idle_zero", i), a_out[i*DW +: DW], 0);
        if (lane_q[i].size() != 0 && lane_q[i][0].cyc_at <= cyc) begin
          check($sformatf("lane%0d_missing", i), a_valid[i], 1);
          void'(lane_q[i].pop_front());
        end
      end
    end

    if (done) begin
      if (done_q.size() == 0) check("done_spurious", done, 0);
      else begin
        ed = done_q.pop_front();
        check("done_edge", cyc, ed);
      end
    end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
      check("done_missing", done, 1);
      void'(done_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    RESET     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < LANES; i++)
        mem[r][i*DW +: DW] = {r[15:0], i[15:0]};

    repeat (3) @(negedge CLK);
    check_reset_state("por");
    RESET = 1'b1;

    // Single row, then a wrapping read 30,31,0,1.
    drive(1'b1, 0, 1);
    idle(22);
    drive(1'b1, 30, 4);
    idle(25);

    // Full buffer, clamped count, and an ignored zero-length request.
    drive(1'b1, 0, 32);
    idle(52);
    drive(1'b1, 5, 40);
    idle(52);
    drive(1'b1, 3, 0);
    idle(20);

    // Starts while busy are ignored; a start held high is taken in the done cycle.
    drive(1'b1, 7, 8);
    idle(2);
    drive(1'b1, 20, 8);
    idle(3);
    while (cyc + 1 < free_edge) drive(1'b1, 9, 5);
    drive(1'b1, 12, 3);
    idle(25);

    // Reset at k+6 of an 8-row transfer, then a short transfer.
    drive(1'b1, 0, 8);
    idle(5);
    do_reset();
    drive(1'b1, 4, 2);
    idle(25);

    // Random data and random requests, including ignored ones while busy.
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < LANES; i++)
        mem[r][i*DW +: DW] = $urandom;
    for (int t = 0; t < 200; t++) begin
      idle($urandom_range(0, 2));
      drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 40));
      while (cyc + 1 < free_edge)
        drive(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 40));
    end

    wait_cyc = 0;
    while (pending() != 0 && wait_cyc < 100) begin
      idle(1);
      wait_cyc++;
    end
    idle(3);
    check("queues_drained", pending(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
